// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin arbiter sharing one synchronous ROM read port among NREQ requesters.
module rom_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int WID     = 8,
    parameter int AW      = 9,
    parameter int ROM_LAT = 2,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [WID-1:0]     rom_q,
    output logic [AW-1:0]      rom_address,
    output logic [NREQ-1:0]    ack,
    output logic [WID-1:0]     rdata,
    output logic [IW-1:0]      grant_id,
    output logic               busy
);
    localparam int CW = $clog2(ROM_LAT + 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;
    state_t state, state_nx;
    logic [IW-1:0] rr_ptr, win, nxt;
    logic [CW-1:0] cnt;
    // Descending scan so the last hit is the first set bit at or after rr_ptr.
    always_comb begin
        win = rr_ptr;
        nxt = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                win = IW'((int'(rr_ptr) + k) % NREQ);
                nxt = IW'((int'(rr_ptr) + k + 1) % NREQ);
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? WAIT : IDLE;
            WAIT:    state_nx = (cnt == CW'(ROM_LAT - 1)) ? RESP : WAIT;
            RESP:    state_nx = GAP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rom_address <= '0;
            rdata       <= '0;
            ack         <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
        end else begin
            state <= state_nx;
            ack   <= (state == RESP) ? NREQ'(1) << grant_id : '0;
            if (state == IDLE && |req) begin
                rom_address <= req_addr[int'(win)*AW +: AW];
                grant_id    <= win;
                rr_ptr      <= nxt;
                cnt         <= '0;
            end
            if (state == WAIT) cnt <= cnt + CW'(1);
            if (state == RESP) rdata <= rom_q;
        end
    end
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed vectors and sequences for the ROM port arbiter, model ROM q = addr[7:0]^8'hA5.
module tb_rom_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req = '0, ack;
    logic [35:0] req_addr = '0;
    logic [7:0]  rom_q, rdata;
    logic [8:0]  rom_address;
    logic [1:0]  grant_id;
    logic        busy;

    logic [2:0]  req2 = '0, ack2;
    logic [26:0] req_addr2 = '0;
    logic [7:0]  rom_q2, rdata2;
    logic [8:0]  rom_address2;
    logic [1:0]  grant_id2;
    logic        busy2;

    logic [7:0] p1a = '0, p1b = '0, p2a = '0;
    int passed = 0, total = 0;

    rom_port_arbiter #(.NREQ(4), .WID(8), .AW(9), .ROM_LAT(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .rom_q(rom_q),
        .rom_address(rom_address), .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy)
    );
    rom_port_arbiter #(.NREQ(3), .WID(8), .AW(9), .ROM_LAT(1)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .req_addr(req_addr2), .rom_q(rom_q2),
        .rom_address(rom_address2), .ack(ack2), .rdata(rdata2), .grant_id(grant_id2), .busy(busy2)
    );

    // Pipelined model ROMs: q valid ROM_LAT edges after the address settles.
    always @(posedge clk) begin
        p1a <= rom_address[7:0] ^ 8'hA5;
        p1b <= p1a;
        p2a <= rom_address2[7:0] ^ 8'hA5;
    end
    assign rom_q  = p1b;
    assign rom_q2 = p2a;

    typedef struct {
        int         port;
        logic [8:0] addr;
        logic [3:0] exp_ack;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        int n;
        vecs[0] = '{1, 9'd5,     4'b0010, 8'hA0};
        vecs[1] = '{2, 9'd31,    4'b0100, 8'hBA};
        vecs[2] = '{0, 9'h1FF,   4'b0001, 8'h5A};
        vecs[3] = '{3, 9'h100,   4'b1000, 8'hA5};
        vecs[4] = '{0, 9'h0AA,   4'b0001, 8'h0F};

        tick();
        tick();
        chk("rst_addr", rom_address, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ack", ack, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Single-cycle requests: each read must still complete.
        for (int v = 0; v < 5; v++) begin
            req_addr = '0;
            req_addr[vecs[v].port*9 +: 9] = vecs[v].addr;
            req = 4'b1 << vecs[v].port;
            tick();
            req = '0;
            chk("vec_addr", rom_address, vecs[v].addr);
            chk("vec_busy1", busy, 1);
            chk("vec_ack1", ack, 0);
            tick();
            tick();
            chk("vec_ack3", ack, 0);
            tick();
            chk("vec_ack4", ack, vecs[v].exp_ack);
            chk("vec_rdata", rdata, vecs[v].exp_rdata);
            chk("vec_gid", grant_id, vecs[v].port);
            tick();
            chk("vec_busy5", busy, 0);
            chk("vec_ack5", ack, 0);
            chk("vec_hold", rdata, vecs[v].exp_rdata);
        end

        // Simultaneous requests from ports 1 and 3 with rr_ptr reset to 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_addr = '0;
        req_addr[9 +: 9] = 9'd5;
        req_addr[27 +: 9] = 9'd7;
        req = 4'b1010;
        for (int c = 1; c <= 4; c++) tick();
        chk("sim_ack1", ack, 4'b0010);
        chk("sim_gid1", grant_id, 1);
        req = 4'b1000;
        for (int c = 5; c <= 9; c++) tick();
        chk("sim_ack3", ack, 4'b1000);
        chk("sim_gid3", grant_id, 3);
        chk("sim_rdata3", rdata, 8'hA2);
        req = '0;
        tick();
        chk("sim_idle", busy, 0);

        // Fairness: all four held, expect rotation 0,1,2,3 every 5 cycles.
        req_addr = '0;
        for (int i = 0; i < 4; i++) req_addr[i*9 +: 9] = 9'(16 + i);
        req = 4'hF;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) tick();
            if (ack != 0) begin
                chk("fair_ack", ack, 4'b1 << (n % 4));
                chk("fair_time", c, 4 + 5 * n);
                chk("fair_rdata", rdata, 8'(16 + n % 4) ^ 8'hA5);
                n++;
            end
        end
        req = '0;
        chk("fair_count", n, 8);
        tick();

        // Reset during the second WAIT cycle aborts the read.
        req_addr = '0;
        req_addr[18 +: 9] = 9'd9;
        req = 4'b0100;
        tick();
        req = '0;
        chk("mid_addr", rom_address, 9);
        chk("mid_gid", grant_id, 2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_addr", rom_address, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gid", grant_id, 0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (ack != 0) n++;
            tick();
        end
        chk("mid_no_ack", n, 0);
        req_addr = '0;
        req_addr[0 +: 9] = 9'd3;
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        tick();
        tick();
        chk("fresh_ack", ack, 4'b0001);
        chk("fresh_rdata", rdata, 8'hA6);
        tick();
        chk("fresh_idle", busy, 0);

        // NREQ=3, ROM_LAT=1: period 4, ack 3 cycles after grant, wrap 2->0.
        for (int i = 0; i < 3; i++) req_addr2[i*9 +: 9] = 9'(i + 1);
        req2 = 3'b111;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) tick();
            if (c == 1) chk("sw_addr", rom_address2, 1);
            if (ack2 != 0) begin
                chk("sw_ack", ack2, 3'b1 << (n % 3));
                chk("sw_time", c, 3 + 4 * n);
                chk("sw_rdata", rdata2, 8'(n % 3 + 1) ^ 8'hA5);
                n++;
            end
        end
        req2 = '0;
        chk("sw_count", n, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Round-robin arbiter that shares one synchronous ROM read port between NREQ independent requesters. Typical requesters are several ROM readers or decrypt cores that fetch ciphertext bytes concurrently. The block owns the ROM address bus, runs one read at a time, and returns the ROM word with a single-cycle acknowledge to the requester that won. It sits between the requesters and the ROM IP.

## Interface
Parameters:
- NREQ, 4: number of requesters, at least 2.
- WID, 8: ROM word width.
- AW, 9: ROM address width.
- ROM_LAT, 2: cycles from rom_address becoming stable to rom_q being valid, at least 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  per-requester read request, level-sensitive.
- req_addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- rom_q  in  WID  ROM read data.
- rom_address  out  AW  registered ROM address.
- ack  out  NREQ  one-hot, one-cycle pulse; rdata is valid for ack[i] in the same cycle.
- rdata  out  WID  registered read data, broadcast to all requesters.
- grant_id  out  $clog2(NREQ)  index of the current or most recent winner.
- busy  out  1  high in every state except IDLE.

## Operation
- States are IDLE, WAIT, RESP and GAP.
- IDLE: if req is nonzero, select the winner.
  - Search starts at rr_ptr, ascends, and wraps from NREQ-1 to 0; the first set bit wins.
  - Latch the winner's req_addr into rom_address and set grant_id to the winner.
  - Set rr_ptr to (winner+1) mod NREQ.
  - Clear the wait counter and go to WAIT.
  - If req is zero, stay in IDLE; rom_address holds its last value.
- WAIT: increment the counter. When it reaches ROM_LAT-1, go to RESP (exactly ROM_LAT cycles in WAIT).
- RESP: capture rdata <= rom_q, set ack[grant_id] <= 1, go to GAP.
- GAP: ack is high for this single cycle. req is ignored. Next cycle ack clears and the state returns to IDLE.
- A granted read always completes, even if the winner drops req after the grant. The address is already latched and the ack is still issued.
- req_addr is sampled only in the IDLE cycle that grants. Later changes do not affect the read in flight.
- A requester that keeps req high after its ack requests another read. The updated rr_ptr places it last in priority, so it cannot starve the others.
- rdata holds its value between acks and changes only in RESP.
- Reset values: state IDLE, rom_address 0, rdata 0, ack 0, grant_id 0, busy 0, rr_ptr 0, counter 0.
- Reset asserted in any state aborts the read in flight: no ack, all registers take their reset values on the next edge.

## Timing
- Let cycle 0 be the IDLE cycle that sees the request.
  - rom_address is valid from cycle 1.
  - WAIT occupies cycles 1 to ROM_LAT; rom_q is sampled in RESP at cycle ROM_LAT+1.
  - ack and rdata are visible at cycle ROM_LAT+2, during GAP.
  - The next arbitration happens at cycle ROM_LAT+3.
- Transaction period is ROM_LAT+3 cycles: 5 cycles at the default ROM_LAT of 2.
- Worst-case wait for a continuously requesting port is (NREQ-1)*(ROM_LAT+3) cycles before its grant.
- busy is high on cycles 1 to ROM_LAT+2 and low in cycle 0 and in every other IDLE cycle.
- ack is never high for more than one cycle and never has more than one bit set.
- Simultaneous events:
  - A request arriving during WAIT, RESP or GAP is held by the requester and considered at the next IDLE.
  - reset wins over every other input.

## Test plan
- Single read, ROM_LAT=2, model ROM with q=addr^8'hA5: req[1] with addr 9'd5 at cycle 0 -> rom_address=5 at cycle 1; ack=4'b0010 and rdata=8'hA0 at cycle 4; busy low at cycle 5.
- Simultaneous requests: req=4'b1010 with rr_ptr=0 -> port 1 acked first at cycle 4, port 3 acked at cycle 9, with grant_id 1 then 3.
- Fairness: all four req held high for 40 cycles -> acks rotate 0,1,2,3,0,... with one ack every 5 cycles and no repeats until all four ports are served.
- Withdrawal: req[2] high for only cycle 0 with addr 9'd31 -> ack[2] still pulses at cycle 4 with rdata equal to ROM[31]; next IDLE sees no request and busy drops.
- Reset mid-read: assert reset in the second WAIT cycle -> no ack is ever issued; next cycle shows rom_address=0, rdata=0, busy=0, grant_id=0; a fresh req[0] then completes normally.
- Parameter sweep: ROM_LAT=1 and NREQ=3 -> ack arrives 3 cycles after the granting IDLE cycle; round-robin wraps from port 2 to port 0.
